life_ctrl: RTL and testbench

- Run controller for the 8x8 Game of Life cell array.
- Loads a seed pattern into the array and steps it one generation at a time.
- Supports free-run, pause and single-step.
- Stops on its own on extinction, still life, period-2 oscillation or a generation limit, and reports generation count and population.
- Sits between the host/test logic and the cell-array top. The array is driven through a seed-load strobe and a step enable, and its cells are read back.

---
 rtl/life_pkg.sv | 22 ++
 rtl/life_popcount.sv | 20 ++
 rtl/life_ctrl.sv | 179 +++++++++++++++++
 tb/tb_life_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared types and defaults for the Game of Life run controller.
package life_pkg;

  localparam int LIFE_N = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STEP,
    ST_EVAL,
    ST_PAUSED,
    ST_DONE
  } life_state_t;

  typedef enum logic [1:0] {
    STAT_LIMIT   = 2'd0,
    STAT_EXTINCT = 2'd1,
    STAT_STILL   = 2'd2,
    STAT_OSC2    = 2'd3
  } life_status_t;

endpackage

// File: rtl/life_popcount.sv
// Combinational population count of the cell array.
module life_popcount
  import life_pkg::*;
#(
  parameter int W     = LIFE_N * LIFE_N,
  parameter int POP_W = 7
) (
  input  logic [W-1:0]     bits_i,
  output logic [POP_W-1:0] count_o
);

  // Written as a flat sum; synthesis rebalances it into an adder tree.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < W; i++) begin
      count_o = count_o + POP_W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/life_ctrl.sv
// Run controller for the NxN Life array: seed load, free-run/pause/step,
// and automatic stop on extinction, still life, period-2 or generation limit.
//
// state  | meaning
// IDLE   | waiting for start_i
// LOAD   | seed strobe to the grid
// STEP   | generation strobe to the grid, snapshot pre-step cells
// EVAL   | new generation visible: count, popcount, termination checks
// PAUSED | holding; pause release or step_i resumes
// DONE   | result held until start_i or abort_i
module life_ctrl
  import life_pkg::*;
#(
  parameter int N     = LIFE_N,
  parameter int GEN_W = 16,
  parameter int POP_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             pause_i,
  input  logic             step_i,
  input  logic [GEN_W-1:0] gen_limit_i,
  input  logic [N*N-1:0]   seed_i,
  input  logic [N*N-1:0]   cells_i,
  output logic [N*N-1:0]   seeds_o,
  output logic             grid_load_o,
  output logic             grid_step_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       status_o,
  output logic [GEN_W-1:0] gen_count_o,
  output logic [POP_W-1:0] pop_count_o
);

  life_state_t        state_q, state_d;
  life_status_t       status_q, status_d;
  logic [N*N-1:0]     seeds_q, seeds_d;
  logic [N*N-1:0]     prev1_q, prev1_d;
  logic [N*N-1:0]     prev2_q, prev2_d;
  logic [GEN_W-1:0]   gen_q, gen_d;
  logic [POP_W-1:0]   pop_q, pop_d;
  logic               load_q, load_d;
  logic               step_q, step_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               step_mode_q, step_mode_d;
  logic               after_load_q, after_load_d;
  logic [POP_W-1:0]   pop_cnt;
  logic [GEN_W:0]     gen_nxt;

  life_popcount #(.W(N * N), .POP_W(POP_W)) u_popcount (
    .bits_i  (cells_i),
    .count_o (pop_cnt)
  );

  // Unsaturated generation number of the cells now visible in EVAL.
  assign gen_nxt = {1'b0, gen_q} + (GEN_W + 1)'(1);

  always_comb begin
    state_d      = state_q;
    status_d     = status_q;
    seeds_d      = seeds_q;
    prev1_d      = prev1_q;
    prev2_d      = prev2_q;
    gen_d        = gen_q;
    pop_d        = pop_q;
    step_mode_d  = step_mode_q;
    after_load_d = 1'b0;

    if (after_load_q) pop_d = pop_cnt;

    if (abort_i) begin
      state_d     = ST_IDLE;
      step_mode_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            seeds_d     = seed_i;
            gen_d       = '0;
            status_d    = STAT_LIMIT;
            step_mode_d = 1'b0;
            state_d     = ST_LOAD;
          end
        end
        ST_LOAD: begin
          after_load_d = 1'b1;
          state_d      = pause_i ? ST_PAUSED : ST_STEP;
        end
        ST_STEP: begin
          prev2_d = prev1_q;
          prev1_d = cells_i;
          state_d = ST_EVAL;
        end
        ST_EVAL: begin
          gen_d       = (&gen_q) ? gen_q : gen_q + GEN_W'(1);
          pop_d       = pop_cnt;
          step_mode_d = 1'b0;
          if (cells_i == '0) begin
            state_d  = ST_DONE;
            status_d = STAT_EXTINCT;
          end else if (cells_i == prev1_q) begin
            state_d  = ST_DONE;
            status_d = STAT_STILL;
          end else if (gen_nxt >= (GEN_W + 1)'(2) && cells_i == prev2_q) begin
            state_d  = ST_DONE;
            status_d = STAT_OSC2;
          end else if (gen_limit_i != '0 && gen_nxt == {1'b0, gen_limit_i}) begin
            state_d  = ST_DONE;
            status_d = STAT_LIMIT;
          end else if (pause_i || step_mode_q) begin
            state_d = ST_PAUSED;
          end else begin
            state_d = ST_STEP;
          end
        end
        ST_PAUSED: begin
          if (!pause_i) begin
            state_d = ST_STEP;
          end else if (step_i) begin
            state_d     = ST_STEP;
            step_mode_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    load_d = (state_d == ST_LOAD);
    step_d = (state_d == ST_STEP);
    busy_d = (state_d == ST_LOAD) || (state_d == ST_STEP) ||
             (state_d == ST_EVAL) || (state_d == ST_PAUSED);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      status_q     <= STAT_LIMIT;
      seeds_q      <= '0;
      prev1_q      <= '0;
      prev2_q      <= '0;
      gen_q        <= '0;
      pop_q        <= '0;
      load_q       <= 1'b0;
      step_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      step_mode_q  <= 1'b0;
      after_load_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      seeds_q      <= seeds_d;
      prev1_q      <= prev1_d;
      prev2_q      <= prev2_d;
      gen_q        <= gen_d;
      pop_q        <= pop_d;
      load_q       <= load_d;
      step_q       <= step_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      step_mode_q  <= step_mode_d;
      after_load_q <= after_load_d;
    end
  end

  assign seeds_o     = seeds_q;
  assign grid_load_o = load_q;
  assign grid_step_o = step_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign status_o    = status_q;
  assign gen_count_o = gen_q;
  assign pop_count_o = pop_q;

endmodule

// File: tb/tb_life_ctrl.sv
// Self-checking bench for life_ctrl with a behavioural 8x8 Life grid.
module tb_life_ctrl;

  localparam int N     = 8;
  localparam int GEN_W = 16;
  localparam int POP_W = 7;

  localparam logic [63:0] GLIDER  = 64'h0000_0000_0007_0402;
  localparam logic [63:0] BLINKER = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;

  localparam int S_LIMIT   = 0;
  localparam int S_EXTINCT = 1;
  localparam int S_STILL   = 2;
  localparam int S_OSC2    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start_i = 1'b0;
  logic             abort_i = 1'b0;
  logic             pause_i = 1'b0;
  logic             step_i = 1'b0;
  logic [GEN_W-1:0] gen_limit_i = '0;
  logic [63:0]      seed_i = '0;
  logic [63:0]      grid;
  logic [63:0]      seeds_o;
  logic             grid_load_o, grid_step_o, busy_o, done_o;
  logic [1:0]       status_o;
  logic [GEN_W-1:0] gen_count_o;
  logic [POP_W-1:0] pop_count_o;

  int checks = 0;
  int errors = 0;
  int load_cnt = 0;
  int step_cnt = 0;
  int overlap_cnt = 0;

  always #5 clk = ~clk;

  life_ctrl #(.N(N), .GEN_W(GEN_W), .POP_W(POP_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .pause_i     (pause_i),
    .step_i      (step_i),
    .gen_limit_i (gen_limit_i),
    .seed_i      (seed_i),
    .cells_i     (grid),
    .seeds_o     (seeds_o),
    .grid_load_o (grid_load_o),
    .grid_step_o (grid_step_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .status_o    (status_o),
    .gen_count_o (gen_count_o),
    .pop_count_o (pop_count_o)
  );

  // Life rule on an 8x8 board with dead cells beyond the edges.
  function automatic logic [63:0] life_next(input logic [63:0] g);
    logic [63:0] n;
    n = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        int cnt;
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr, cc;
            rr = r + dr;
            cc = c + dc;
            if ((dr != 0 || dc != 0) && rr >= 0 && rr < N && cc >= 0 && cc < N)
              if (g[rr*N+cc]) cnt++;
          end
        end
        n[r*N+c] = (cnt == 3) || (g[r*N+c] && cnt == 2);
      end
    end
    return n;
  endfunction

  // Grid model and strobe monitor.
  always @(posedge clk) begin
    if (!rst) grid <= '0;
    else if (grid_load_o) grid <= seeds_o;
    else if (grid_step_o) grid <= life_next(grid);
    if (grid_load_o) load_cnt <= load_cnt + 1;
    if (grid_step_o) step_cnt <= step_cnt + 1;
    if (grid_load_o && grid_step_o) overlap_cnt <= overlap_cnt + 1;
  end

  // Reference: evolve a history of generations and apply the stop rules.
  task automatic ref_run(input logic [63:0] seed, input int limit,
                         output int gen, output int status, output int pop);
    logic [63:0] hist[$];
    logic [63:0] nxt;
    hist.push_back(seed);
    gen = 0;
    status = -1;
    nxt = seed;
    while (status < 0 && gen < 1000) begin
      nxt = life_next(hist[gen]);
      gen++;
      if (nxt == 0) status = S_EXTINCT;
      else if (nxt == hist[gen-1]) status = S_STILL;
      else if (gen >= 2 && nxt == hist[gen-2]) status = S_OSC2;
      else if (limit != 0 && gen == limit) status = S_LIMIT;
      hist.push_back(nxt);
    end
    pop = $countones(nxt);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_run(input logic [63:0] seed, input int limit);
    seed_i      = seed;
    gen_limit_i = limit[GEN_W-1:0];
    start_i     = 1'b1;
    tick(1);
    start_i     = 1'b0;
  endtask

  task automatic wait_gen(input int g, input string name);
    int n;
    n = 0;
    while (gen_count_o != g[GEN_W-1:0] && n < 200) begin
      tick(1);
      n++;
    end
    check({name, " reach_gen"}, gen_count_o, g);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done_o && n < 200) begin
      tick(1);
      n++;
    end
    check({name, " done_reached"}, done_o, 1);
  endtask

  task automatic run_case(input string name, input logic [63:0] seed, input int limit,
                          input int eg, input int es, input int ep);
    int cyc, l0, s0;
    l0 = load_cnt;
    s0 = step_cnt;
    start_run(seed, limit);
    cyc = 1;
    while (!done_o && cyc < 300) begin
      tick(1);
      cyc++;
    end
    check({name, " done_latency"}, cyc, 2 + 2 * eg);
    check({name, " gen"}, gen_count_o, eg);
    check({name, " status"}, status_o, es);
    check({name, " pop"}, pop_count_o, ep);
    check({name, " busy"}, busy_o, 0);
    check({name, " seeds"}, seeds_o, seed);
    check({name, " loads"}, load_cnt - l0, 1);
    check({name, " steps"}, step_cnt - s0, eg);
  endtask

  typedef struct {
    logic [63:0] seed;
    int          limit;
    int          gen;
    int          status;
    int          pop;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int l0, s0, sc, lc;

    tbl[0] = '{seed: GLIDER,  limit: 5, gen: 5, status: S_LIMIT,   pop: 5};
    tbl[1] = '{seed: BLINKER, limit: 0, gen: 2, status: S_OSC2,    pop: 3};
    tbl[2] = '{seed: BLOCK,   limit: 0, gen: 1, status: S_STILL,   pop: 4};
    tbl[3] = '{seed: 64'h1,   limit: 0, gen: 1, status: S_EXTINCT, pop: 0};

    // Reset state
    tick(3);
    check("rst seeds", seeds_o, 0);
    check("rst gen", gen_count_o, 0);
    check("rst pop", pop_count_o, 0);
    check("rst flags", {grid_load_o, grid_step_o, busy_o, done_o, status_o}, 0);
    rst = 1'b1;
    tick(2);
    check("idle no strobes", load_cnt + step_cnt, 0);

    // Blinker first-generation shape through the grid
    start_run(BLINKER, 0);
    tick(2);
    check("blinker gen1 cells", grid, 64'h0000_0008_0808_0000);
    wait_done("blinker_pre");

    for (int i = 0; i < 4; i++)
      run_case($sformatf("vec%0d", i), tbl[i].seed, tbl[i].limit,
               tbl[i].gen, tbl[i].status, tbl[i].pop);

    // Load straight into PAUSED; population taken the cycle after LOAD
    s0 = step_cnt;
    pause_i = 1'b1;
    start_run(BLINKER, 0);
    tick(2);
    check("loadpause pop", pop_count_o, 3);
    check("loadpause gen", gen_count_o, 0);
    check("loadpause busy", busy_o, 1);
    check("loadpause steps", step_cnt - s0, 0);
    abort_i = 1'b1;
    tick(1);
    abort_i = 1'b0;
    pause_i = 1'b0;
    check("abort paused busy", busy_o, 0);
    check("abort paused done", done_o, 0);

    // Pause at generation 2, three single steps, then resume to the limit
    s0 = step_cnt;
    l0 = load_cnt;
    start_run(GLIDER, 8);
    wait_gen(1, "pause");
    pause_i = 1'b1;
    tick(6);
    check("pause gen", gen_count_o, 2);
    check("pause busy", busy_o, 1);
    check("pause done", done_o, 0);
    sc = step_cnt;
    tick(5);
    check("pause hold", step_cnt, sc);
    seed_i  = BLINKER;
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    tick(3);
    check("start in paused loads", load_cnt - l0, 1);
    check("start in paused seeds", seeds_o, GLIDER);
    check("start in paused gen", gen_count_o, 2);
    for (int k = 1; k <= 3; k++) begin
      step_i = 1'b1;
      tick(1);
      step_i = 1'b0;
      tick(4);
      check($sformatf("single step%0d strobes", k), step_cnt - sc, k);
      check($sformatf("single step%0d gen", k), gen_count_o, 2 + k);
      check($sformatf("single step%0d busy", k), busy_o, 1);
    end
    pause_i = 1'b0;
    wait_done("resume");
    check("resume gen", gen_count_o, 8);
    check("resume status", status_o, S_LIMIT);
    check("resume pop", pop_count_o, 5);
    check("resume steps", step_cnt - s0, 8);

    // abort_i and start_i together in DONE
    l0 = load_cnt;
    seed_i  = BLINKER;
    start_i = 1'b1;
    abort_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    abort_i = 1'b0;
    check("abort beats start done", done_o, 0);
    check("abort beats start busy", busy_o, 0);
    check("abort beats start gen", gen_count_o, 8);
    check("abort beats start seeds", seeds_o, GLIDER);
    tick(3);
    check("abort beats start loads", load_cnt - l0, 0);

    // Abort during STEP
    start_run(GLIDER, 0);
    wait_gen(3, "abort");
    check("abort in step", grid_step_o, 1);
    abort_i = 1'b1;
    tick(1);
    abort_i = 1'b0;
    check("abort busy", busy_o, 0);
    check("abort strobes", {grid_load_o, grid_step_o}, 0);
    sc = step_cnt;
    lc = load_cnt;
    tick(10);
    check("abort quiet", (step_cnt - sc) + (load_cnt - lc), 0);
    check("abort gen hold", gen_count_o, 3);
    check("abort done", done_o, 0);

    // Reset during EVAL
    start_run(GLIDER, 0);
    wait_gen(1, "rst_eval");
    tick(1);
    rst = 1'b0;
    tick(1);
    check("rst eval seeds", seeds_o, 0);
    check("rst eval gen", gen_count_o, 0);
    check("rst eval pop", pop_count_o, 0);
    check("rst eval flags", {grid_load_o, grid_step_o, busy_o, done_o, status_o}, 0);
    rst = 1'b1;
    sc = step_cnt;
    tick(10);
    check("rst eval quiet", step_cnt - sc, 0);
    check("rst eval idle", busy_o, 0);

    // Randomized seeds against the reference model
    for (int i = 0; i < 30; i++) begin
      logic [63:0] s;
      int lim, eg, es, ep;
      s = {$urandom, $urandom};
      if (i % 2 == 0) s = s & {$urandom, $urandom};
      lim = $urandom_range(24, 1);
      ref_run(s, lim, eg, es, ep);
      run_case($sformatf("rnd%0d", i), s, lim, eg, es, ep);
    end

    check("load step overlap", overlap_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
